// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg
// Shared types and constants for the segmented pipelined adder.
//   mode_e        : operation select carried on the operand bus (ADD / SUB)
//   DEF_WIDTH     : default operand/result width
//   DEF_SEG_W     : default number of bits added per pipeline stage
//   stage_count() : number of pipeline stages for a width / segment pair
package pipe_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG_W = 8;

  function automatic int stage_count(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if
// Operand/result handshake bundle for pipe_adder.
//   in_valid/in_ready      : operand transfer handshake
//   a, b, c_in, mode       : operands, carry/borrow-in, ADD/SUB select
//   out_valid/out_ready    : result transfer handshake
//   s, c_out, ovf          : result, carry-out (not-borrow on SUB), signed overflow
// Modports: master = operand producer / result consumer, slave = the adder.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  mode_e            mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, mode, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, mode, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );

endinterface

// File: rtl/pa_seg.sv
// pa_seg
// Combinational SEG_W-bit adder slice used by every pipeline stage.
//   a, b   : segment operands
//   c_in   : carry into the segment
//   sum    : segment sum
//   c_out  : carry out of the segment MSB
//   c_msb  : carry into the segment MSB (used for signed overflow on the top slice)
module pa_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             c_in,
  output logic [SEG_W-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [SEG_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, c_in};
  assign sum   = total[SEG_W-1:0];
  assign c_out = total[SEG_W];
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out
  // without a second adder.
  assign c_msb = a[SEG_W-1] ^ b[SEG_W-1] ^ sum[SEG_W-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder
// Pipelined ADD/SUB that adds SEG_W bits per stage, STAGES = WIDTH/SEG_W.
// Latency is STAGES cycles, throughput one result per cycle, with a global
// stall (in_ready = !out_valid || out_ready).
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset; drops every in-flight operation
//   bus  : pipe_adder_if.slave (operand handshake in, result handshake out)
// Optional build macro PIPE_ADDER_SAT_EN: clamp s to the signed min/max when
// ovf is set (c_out and ovf still report the raw flags). Without it s is the
// wrapped modulo-2^WIDTH result.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input logic         clk,
  input logic         rst,
  pipe_adder_if.slave bus
);

  localparam int STAGES = stage_count(WIDTH, SEG_W);
  localparam int LAST   = STAGES - 1;

  if (WIDTH % SEG_W != 0) begin : g_bad_width
    $error("pipe_adder: WIDTH must be an integer multiple of SEG_W");
  end

  logic              advance;
  logic [STAGES-1:0] valid_reg;    // valid_reg[k] qualifies the register feeding slice k+1 (last = output)
  logic [STAGES-1:0] stage_valid;  // stage_valid[k] qualifies the operands presented to slice k
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  // Whole pipeline moves together; it only stops when the output is held.
  assign advance      = !valid_reg[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  // SUB is a + ~b + ~c_in, so a single adder serves both modes.
  assign b_eff = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
  assign c_eff = (bus.mode == MODE_SUB) ? ~bus.c_in : bus.c_in;

  always_comb begin
    stage_valid    = '0;
    stage_valid[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      stage_valid[k] = valid_reg[k-1];
    end
  end

  // Slice gi adds segment gi. Its operand view op_a/op_b holds segments
  // gi..STAGES-1 only: consumed low segments are dropped and the upper ones
  // ride along, which provides the skew that lines each segment up with its
  // registered carry. sum_out accumulates the finished low segments.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int OP_W = WIDTH - gi * SEG_W;

    logic [OP_W-1:0]         op_a;
    logic [OP_W-1:0]         op_b;
    logic                    op_c;
    logic [SEG_W-1:0]        seg_sum;
    logic                    seg_cout;
    logic                    seg_cmsb;
    logic [(gi+1)*SEG_W-1:0] sum_out;

    if (gi == 0) begin : g_head
      assign op_a    = bus.a;
      assign op_b    = b_eff;
      assign op_c    = c_eff;
      assign sum_out = seg_sum;
    end else begin : g_body
      logic [OP_W-1:0]       a_reg;
      logic [OP_W-1:0]       b_reg;
      logic                  carry_reg;
      logic [gi*SEG_W-1:0]   sum_reg;

      // Data only loads behind a valid entry; bubbles leave it untouched.
      always_ff @(posedge clk) begin
        if (advance && stage_valid[gi-1]) begin
          a_reg     <= g_stage[gi-1].op_a[OP_W+SEG_W-1:SEG_W];
          b_reg     <= g_stage[gi-1].op_b[OP_W+SEG_W-1:SEG_W];
          carry_reg <= g_stage[gi-1].seg_cout;
          sum_reg   <= g_stage[gi-1].sum_out;
        end
      end

      assign op_a    = a_reg;
      assign op_b    = b_reg;
      assign op_c    = carry_reg;
      assign sum_out = {seg_sum, sum_reg};
    end

    pa_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a     (op_a[SEG_W-1:0]),
      .b     (op_b[SEG_W-1:0]),
      .c_in  (op_c),
      .sum   (seg_sum),
      .c_out (seg_cout),
      .c_msb (seg_cmsb)
    );
  end

  logic [WIDTH-1:0] s_next;
  logic             ovf_next;
  logic [WIDTH-1:0] s_reg;
  logic             c_out_reg;
  logic             ovf_reg;

  assign ovf_next = g_stage[LAST].seg_cout ^ g_stage[LAST].seg_cmsb;

`ifdef PIPE_ADDER_SAT_EN
  // On overflow the true result has the sign of a (operand signs agree
  // after the SUB inversion), so a's MSB picks the clamp direction.
  always_comb begin
    s_next = g_stage[LAST].sum_out;
    if (ovf_next) begin
      s_next = g_stage[LAST].op_a[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign s_next = g_stage[LAST].sum_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      s_reg     <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (advance) begin
      valid_reg <= stage_valid;
      // Output fields only change with a real result, so they read 0 after
      // reset until the first new result arrives.
      if (stage_valid[LAST]) begin
        s_reg     <= s_next;
        c_out_reg <= g_stage[LAST].seg_cout;
        ovf_reg   <= ovf_next;
      end
    end
  end

  assign bus.out_valid = valid_reg[LAST];
  assign bus.s         = s_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder
// Randomised and directed checks of pipe_adder (WIDTH=32, SEG_W=8) against a
// plain-arithmetic reference model and an in-order scoreboard.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int WIDTH  = 32;
  localparam int SEG_W  = 8;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst;

  pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  pipe_adder #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        c_out;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_count = 0;
  int          stall_cycles = 0;
  bit          lat_check = 1'b0;
  bit          stalled_prev = 1'b0;
  bit          rnd_done = 1'b0;
  logic [33:0] prev_out = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: true signed and unsigned results in 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input mode_e m, input int acc);
    exp_t   e;
    longint sa, sb, ua, ub, cl, sr, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    cl = longint'({63'd0, c});
    if (m == MODE_ADD) begin
      sr = sa + sb + cl;
      ur = ua + ub + cl;
      e.c_out = (ur >= (longint'(1) << 32));
    end else begin
      sr = sa - sb - cl;
      ur = ua - ub - cl;
      e.c_out = (ur >= 0);
    end
    e.ovf = (sr > longint'(32'h7FFF_FFFF)) || (sr < -longint'(32'h8000_0000));
    e.s   = ur[31:0];
`ifdef PIPE_ADDER_SAT_EN
    if (e.ovf) e.s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor / scoreboard: all handshakes are judged mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        stalled_prev = 1'b0;
      end else begin
        if (bus.out_valid && !bus.out_ready) begin
          stall_cycles++;
          check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
          if (stalled_prev) check("stall_hold", {30'd0, bus.s, bus.c_out, bus.ovf}, {30'd0, prev_out});
        end
        stalled_prev = bus.out_valid && !bus.out_ready;
        prev_out     = {bus.s, bus.c_out, bus.ovf};
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("s", {32'd0, bus.s}, {32'd0, e.s});
            check("c_out", {63'd0, bus.c_out}, {63'd0, e.c_out});
            check("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
            if (lat_check) check("latency", 64'(cyc - e.acc), 64'(STAGES));
            $display("txn %0d s=%08h c_out=%0b ovf=%0b", out_count, bus.s, bus.c_out, bus.ovf);
          end
          out_count++;
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.mode, cyc));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input mode_e m);
    bit done = 1'b0;
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = c;
    bus.mode     = m;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          check("send_timeout", 64'(waited), 64'd0);
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_a [4];
  logic [31:0] dir_b [4];
  logic        dir_c [4];
  mode_e       dir_m [4];
  int          base_out;
  int          base_stall;
  int          gap;

  initial begin
    dir_a = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
    dir_b = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007};
    dir_c = '{1'b0, 1'b1, 1'b0, 1'b0};
    dir_m = '{MODE_ADD, MODE_ADD, MODE_ADD, MODE_SUB};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.mode      = MODE_ADD;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_s", {32'd0, bus.s}, 64'd0);
    check("rst_c_out", {63'd0, bus.c_out}, 64'd0);
    check("rst_ovf", {63'd0, bus.ovf}, 64'd0);
    @(posedge clk);
    #1;

    // Directed corner vectors, one at a time, latency checked.
    lat_check = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(dir_a[i], dir_b[i], dir_c[i], dir_m[i]);
      drain();
    end

    // Reset with three operations in flight: nothing may come out.
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, MODE_ADD);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);
      check("post_rst_out", {30'd0, bus.s, bus.c_out, bus.ovf}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Back-to-back stream of 8 with a 3-cycle consumer stall mid-stream.
    lat_check  = 1'b0;
    base_out   = out_count;
    base_stall = stall_cycles;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), mode_e'(1'($urandom_range(0, 1))));
      end
      begin
        repeat (7) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(out_count - base_out), 64'd8);
    check("stream_stall_cycles", 64'(stall_cycles - base_stall), 64'd3);

    // Random traffic with random input gaps and random backpressure.
    base_out = out_count;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), mode_e'(1'($urandom_range(0, 1))));
          gap = int'($urandom_range(0, 2));
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("random_count", 64'(out_count - base_out), 64'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter SEG_W, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG_W (elaboration error otherwise).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operands and mode present this cycle.
REQ-006 SHALL have port in_ready, output, 1: pipeline accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port c_in, input, 1: carry-in (ADD) or borrow-in (SUB).
REQ-010 SHALL have port mode, input, 1: 0 = ADD, 1 = SUB.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port s, output, WIDTH: result.
REQ-014 SHALL have port c_out, output, 1: carry-out (ADD), or not-borrow (SUB).
REQ-015 SHALL have port ovf, output, 1: two's-complement signed overflow of the result.

Function
REQ-016 SHALL use STAGES = WIDTH/SEG_W pipeline stages; stage k adds bits [k*SEG_W +: SEG_W] using the carry registered from stage k-1.
REQ-017 SHALL compute ADD as a + b + c_in and SUB as a + ~b + ~c_in (i.e. a - b - c_in).
REQ-018 SHALL accept a transfer when in_valid && in_ready.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (global stall; no input-side skid).
REQ-020 SHALL present each result exactly STAGES cycles after acceptance when no stall occurs; throughput SHALL be one result per cycle.
REQ-021 SHALL freeze all stage registers, including valid bits, while out_valid && !out_ready; s, c_out and ovf SHALL stay stable until the transfer completes.
REQ-022 SHALL propagate a bubble (valid=0) through any stage not loaded by an accepted transfer; results SHALL remain in order.
REQ-023 SHALL skew unprocessed operand segments through register delay so that each upper segment meets its carry in the correct stage.
REQ-024 SHALL compute ovf = carry into MSB XOR carry out of MSB on the final stage.
REQ-025 SHALL, for STAGES = 1, degenerate to a single registered adder with latency 1.

Reset
REQ-026 SHALL clear all valid bits, s, c_out and ovf to 0 on rst; in_ready SHALL therefore read 1 in the cycle after reset.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no result for them SHALL appear afterwards.
REQ-028 SHALL give rst priority over in_valid in the same cycle (the operation is not accepted).

Configuration
REQ-029 SHALL, when macro PIPE_ADDER_SAT_EN is defined, saturate s on ovf=1: 2^(WIDTH-1)-1 if the true result is positive (a MSB = 0), else -2^(WIDTH-1); ovf and c_out SHALL still report the raw flags.
REQ-030 SHALL, when PIPE_ADDER_SAT_EN is undefined, output the wrapped modulo-2^WIDTH result with no saturation logic present.

Structure
REQ-031 SHALL place the mode_e enum (MODE_ADD, MODE_SUB) in package pipe_adder_pkg.
REQ-032 SHALL instantiate one combinational sub-module pa_seg (SEG_W-bit adder: a, b, c_in -> sum, c_out, c_msb) per stage via a generate loop.

Verification (WIDTH=32, SEG_W=8)
REQ-033 SHALL cover: ADD 0x0000_00FF + 0x0000_0001, c_in=0 -> s=0x0000_0100, c_out=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-034 SHALL cover: ADD 0xFFFF_FFFF + 0x0000_0000, c_in=1 -> s=0x0000_0000, c_out=1, ovf=0 (full carry ripple across all stages).
REQ-035 SHALL cover: ADD 0x7FFF_FFFF + 0x0000_0001 -> ovf=1; s=0x8000_0000 without the macro, s=0x7FFF_FFFF with PIPE_ADDER_SAT_EN.
REQ-036 SHALL cover: SUB 0x0000_0005 - 0x0000_0007, c_in=0 -> s=0xFFFF_FFFE, c_out=0, ovf=0.
REQ-037 SHALL cover: back-to-back stream of 8 operations with out_ready held low for 3 cycles mid-stream -> in_ready=0 during the stall, no loss or duplication, results in order.
REQ-038 SHALL cover: rst asserted for 1 cycle with 3 operations in flight -> out_valid=0 and outputs 0 afterwards, and no stale result emerges.
